srio_ram_bus_arbiter: RTL and testbench
=======================================

# srio_ram_bus_arbiter

Two-port arbiter and sequencer for the shared 64-bit local RAM bus (wr/rd strobes, 32-bit address, 64-bit data, 8-bit byte-select). Port A is the SRIO target side and port B is the local/Aurora side. The block grants the bus to one requester at a time with round-robin fairness and a bounded burst length. It registers the winning requester's strobes onto the RAM and steers returning read data back to the port that issued each read.

## Interface
- MAX_BURST, 16, accesses a granted port may issue before it must yield to a pending other port (1..255)
- RD_LAT, 1, RAM read latency: cycles from ram_rd to valid ram_dout (1..4)

- sys_clk  in  1  single clock
- sys_rst_n  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  level request to own the bus
- a_gnt / b_gnt  out  1  registered grant
- a_wr, a_rd / b_wr, b_rd  in  1  single-cycle access strobes; valid only while that port's gnt is high
- a_addr / b_addr  in  32  word address
- a_din / b_din  in  64  write data
- a_bus_sel / b_bus_sel  in  8  byte enables, bit n = byte n
- a_rdata / b_rdata  out  64  read data (ram_dout passed through)
- a_rvalid / b_rvalid  out  1  one-cycle qualifier for rdata
- ram_wr, ram_rd  out  1  RAM strobes
- ram_addr  out  32;  ram_din  out  64;  ram_bus_sel  out  8
- ram_dout  in  64  RAM read data
- err_illegal  out  2  sticky error flags, bit0 = A, bit1 = B
- err_clr  in  1  synchronous clear of err_illegal

## Operation
- States are IDLE, OWN_A and OWN_B, one-hot. The state register directly drives a_gnt and b_gnt.
- **IDLE.** If exactly one req is high, go to that port's OWN state. If both are high, go to the port that is not `last_owner`. `last_owner` resets to B, so A wins the first tie.
- **OWN_x, voluntary release.** If x_req is low, go to IDLE and set `last_owner` = x.
- **OWN_x, forced release.** If `burst_cnt` == MAX_BURST and the other port's req is high, go to IDLE and set `last_owner` = x.
- **Idle gap.** There is always at least one IDLE cycle between two ownerships, including back-to-back requests from the same port.
- **Accepted access.** An access is accepted when the port's gnt is high and its wr or rd strobe is high.
  - On acceptance, ram_* are registered from that port's signals on the next clock.
  - When no access is accepted, ram_wr and ram_rd are 0. ram_addr, ram_din and ram_bus_sel hold their last values.
- **Illegal access** sets the port's err_illegal bit:
  - a strobe while the port's gnt is low: the strobe is ignored;
  - wr and rd high together: the write is performed and the read is dropped.
- **err_illegal clear.** err_clr clears both bits. If a set event and err_clr occur in the same cycle, the set wins.
- **burst_cnt** (8 bit):
  - cleared in IDLE;
  - increments on each accepted access;
  - saturates at MAX_BURST;
  - the owner keeps the bus past saturation while the other port's req stays low.
- **Read tag pipeline.** A shift register of depth RD_LAT+1 carries {valid, port} for each accepted read.
  - Its output raises a_rvalid or b_rvalid exactly when ram_dout is valid.
  - Reads still in flight after a grant change still return to the port that issued them.
- a_rdata and b_rdata both equal ram_dout at all times. Only rvalid is steered.

## Timing
- **Reset values:** state IDLE, gnt 0/0, ram_wr/ram_rd 0, ram_addr/ram_din/ram_bus_sel 0, rvalid 0/0, err_illegal 00, burst_cnt 0, `last_owner` B, tag pipeline empty.
- **Request to grant:** req high in cycle t (state IDLE) → gnt high at t+1.
- **Release:** req low at t → gnt low at t+1 → earliest grant to the other port at t+2.
- **Forced release:** if the MAX_BURST-th acceptance is at t and the other req is high, gnt drops at t+1. At most MAX_BURST accesses are accepted per ownership while the other port waits.
- **Write:** strobe accepted at t → ram_wr at t+1.
- **Read:** strobe accepted at t → ram_rd at t+1 → x_rvalid at t+1+RD_LAT.
- **Throughput:** sustained one access per cycle while granted.
- **Reset mid-operation:** asynchronous reset returns all registers to reset values immediately. In-flight reads are discarded and produce no rvalid.

## Test plan
- **Single read, RD_LAT=1:** A reqs at t0, gets gnt at t1, strobes a_rd addr 0x40 at t1 → ram_rd and ram_addr 0x40 at t2; ram_dout 0x1122334455667788 at t3 → a_rvalid=1 at t3 with that data; b_rvalid stays 0.
- **Tie and round robin:** both reqs high from reset → A granted first. A drops req → one IDLE cycle, then B granted. Both reqs high again → A granted next (`last_owner` = B).
- **Forced release, MAX_BURST=4:** A streams writes with B requesting → exactly 4 ram_wr pulses, a_gnt drops the following cycle, IDLE cycle, then b_gnt=1.
- **Read across handover, RD_LAT=3:** A's last read accepted, then A releases, then B reads → rvalid pulses arrive in order, first on a_rvalid, then on b_rvalid.
- **Illegal access:** b_wr while b_gnt=0 → no ram_wr and err_illegal=10. A wr+rd together → write performed, no ram_rd, err_illegal=11. err_clr → 00.
- **Reset mid-burst:** assert sys_rst_n low with two reads in flight → all outputs at reset values the same cycle and no rvalid after reset release.

Source files
------------

// File: rtl/srio_ram_bus_arbiter_if.sv
// Shared RAM bus bundle: two requester ports (A = SRIO target, B = local/Aurora),
// the RAM-facing strobes/data and the sticky error flags.
interface srio_ram_bus_arbiter_if;
  logic        a_req, b_req;
  logic        a_gnt, b_gnt;
  logic        a_wr, a_rd, b_wr, b_rd;
  logic [31:0] a_addr, b_addr;
  logic [63:0] a_din, b_din;
  logic [7:0]  a_bus_sel, b_bus_sel;
  logic [63:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid;
  logic        ram_wr, ram_rd;
  logic [31:0] ram_addr;
  logic [63:0] ram_din;
  logic [7:0]  ram_bus_sel;
  logic [63:0] ram_dout;
  logic [1:0]  err_illegal;
  logic        err_clr;

  // Arbiter side
  modport slave (
    input  a_req, b_req, a_wr, a_rd, b_wr, b_rd, a_addr, b_addr,
           a_din, b_din, a_bus_sel, b_bus_sel, ram_dout, err_clr,
    output a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
           ram_wr, ram_rd, ram_addr, ram_din, ram_bus_sel, err_illegal
  );

  // Requesters plus RAM side
  modport master (
    output a_req, b_req, a_wr, a_rd, b_wr, b_rd, a_addr, b_addr,
           a_din, b_din, a_bus_sel, b_bus_sel, ram_dout, err_clr,
    input  a_gnt, b_gnt, a_rdata, b_rdata, a_rvalid, b_rvalid,
           ram_wr, ram_rd, ram_addr, ram_din, ram_bus_sel, err_illegal
  );
endinterface

// File: rtl/srio_ram_bus_arbiter.sv
// Two-port round-robin arbiter for the 64-bit local RAM bus with bounded
// bursts, registered RAM strobes and read-data steering by issuing port.
module srio_ram_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int RD_LAT    = 1
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  srio_ram_bus_arbiter_if.slave       bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    OWN_A = 3'b010,
    OWN_B = 3'b100
  } state_t;

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  state_t      state_q, state_d;
  logic        last_b_q, last_b_d;        // 1: B owned the bus most recently
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        acc_a, acc_b, rd_acc, burst_done;
  logic        ill_a, ill_b;
  logic [1:0]  err_q, err_d;
  logic        ram_wr_q, ram_rd_q;
  logic [31:0] ram_addr_q;
  logic [63:0] ram_din_q;
  logic [7:0]  ram_bus_sel_q;
  logic [RD_LAT:0] vld_pipe, port_pipe;   // port_pipe bit: 1 = read issued by B

  // One-hot state bits are the grants.
  assign bus.a_gnt = state_q[1];
  assign bus.b_gnt = state_q[2];

  assign acc_a  = bus.a_gnt & (bus.a_wr | bus.a_rd);
  assign acc_b  = bus.b_gnt & (bus.b_wr | bus.b_rd);
  // A combined wr+rd keeps the write, so only a lone rd enters the tag pipe.
  assign rd_acc = (acc_a & bus.a_rd & ~bus.a_wr) | (acc_b & bus.b_rd & ~bus.b_wr);

  assign ill_a = (bus.a_wr | bus.a_rd) & (~bus.a_gnt | (bus.a_wr & bus.a_rd));
  assign ill_b = (bus.b_wr | bus.b_rd) & (~bus.b_gnt | (bus.b_wr & bus.b_rd));

  // Burst counter: zero while idle, saturating count of accepted accesses.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (state_q == IDLE)
      burst_cnt_d = '0;
    else if ((acc_a | acc_b) && burst_cnt_q != MAXB)
      burst_cnt_d = burst_cnt_q + 8'd1;
  end

  // Yield as soon as the limit is reached this cycle so the grant drops next cycle.
  assign burst_done = (burst_cnt_d == MAXB);

  // Next-state: tie goes to the port that did not own last; every release passes IDLE.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    unique case (state_q)
      IDLE: begin
        if (bus.a_req && bus.b_req) state_d = last_b_q ? OWN_A : OWN_B;
        else if (bus.a_req)         state_d = OWN_A;
        else if (bus.b_req)         state_d = OWN_B;
      end
      OWN_A: begin
        if (!bus.a_req || (burst_done && bus.b_req)) begin
          state_d  = IDLE;
          last_b_d = 1'b0;
        end
      end
      OWN_B: begin
        if (!bus.b_req || (burst_done && bus.a_req)) begin
          state_d  = IDLE;
          last_b_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky errors: set has priority over clear.
  always_comb begin
    err_d = bus.err_clr ? 2'b00 : err_q;
    err_d = err_d | {ill_b, ill_a};
  end

  // Arbitration state, counter and error flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      burst_cnt_q <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
    end
  end

  // Register the winning port's access onto the RAM; address/data hold when idle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_wr_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_bus_sel_q <= '0;
    end else if (acc_a) begin
      ram_wr_q      <= bus.a_wr;
      ram_rd_q      <= bus.a_rd & ~bus.a_wr;
      ram_addr_q    <= bus.a_addr;
      ram_din_q     <= bus.a_din;
      ram_bus_sel_q <= bus.a_bus_sel;
    end else if (acc_b) begin
      ram_wr_q      <= bus.b_wr;
      ram_rd_q      <= bus.b_rd & ~bus.b_wr;
      ram_addr_q    <= bus.b_addr;
      ram_din_q     <= bus.b_din;
      ram_bus_sel_q <= bus.b_bus_sel;
    end else begin
      ram_wr_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
    end
  end

  // Read tags: stage 0 lines up with ram_rd, stage RD_LAT with valid ram_dout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], rd_acc};
      port_pipe <= {port_pipe[RD_LAT-1:0], acc_b};
    end
  end

  assign bus.a_rvalid    = vld_pipe[RD_LAT] & ~port_pipe[RD_LAT];
  assign bus.b_rvalid    = vld_pipe[RD_LAT] &  port_pipe[RD_LAT];
  assign bus.a_rdata     = bus.ram_dout;
  assign bus.b_rdata     = bus.ram_dout;
  assign bus.ram_wr      = ram_wr_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.ram_bus_sel = ram_bus_sel_q;
  assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_srio_ram_bus_arbiter.sv
// Random bench for srio_ram_bus_arbiter: two instances (different burst limit
// and read latency) share one stimulus and are each checked every cycle
// against a transaction-level reference model.
module tb_srio_ram_bus_arbiter;
  localparam int MB0 = 4, RL0 = 1;
  localparam int MB1 = 1, RL1 = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  logic        a_req, b_req, a_wr, a_rd, b_wr, b_rd, err_clr;
  logic [31:0] a_addr, b_addr;
  logic [63:0] a_din, b_din, ram_dout;
  logic [7:0]  a_bus_sel, b_bus_sel;

  srio_ram_bus_arbiter_if bus0 ();
  srio_ram_bus_arbiter_if bus1 ();

  assign bus0.a_req = a_req;         assign bus1.a_req = a_req;
  assign bus0.b_req = b_req;         assign bus1.b_req = b_req;
  assign bus0.a_wr = a_wr;           assign bus1.a_wr = a_wr;
  assign bus0.a_rd = a_rd;           assign bus1.a_rd = a_rd;
  assign bus0.b_wr = b_wr;           assign bus1.b_wr = b_wr;
  assign bus0.b_rd = b_rd;           assign bus1.b_rd = b_rd;
  assign bus0.a_addr = a_addr;       assign bus1.a_addr = a_addr;
  assign bus0.b_addr = b_addr;       assign bus1.b_addr = b_addr;
  assign bus0.a_din = a_din;         assign bus1.a_din = a_din;
  assign bus0.b_din = b_din;         assign bus1.b_din = b_din;
  assign bus0.a_bus_sel = a_bus_sel; assign bus1.a_bus_sel = a_bus_sel;
  assign bus0.b_bus_sel = b_bus_sel; assign bus1.b_bus_sel = b_bus_sel;
  assign bus0.ram_dout = ram_dout;   assign bus1.ram_dout = ram_dout;
  assign bus0.err_clr = err_clr;     assign bus1.err_clr = err_clr;

  srio_ram_bus_arbiter #(.MAX_BURST(MB0), .RD_LAT(RL0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus0.slave));
  srio_ram_bus_arbiter #(.MAX_BURST(MB1), .RD_LAT(RL1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus1.slave));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model per instance: owner 0 none / 1 A / 2 B; expected read
  // returns are scheduled into a ring indexed by the cycle they must appear in.
  int          m_own [2];
  int          m_last[2];
  int          m_cnt [2];
  bit          m_wr  [2];
  bit          m_rd  [2];
  logic [31:0] m_addr[2];
  logic [63:0] m_din [2];
  logic [7:0]  m_sel [2];
  logic [1:0]  m_err [2];
  bit [1:0]    m_rv  [2][16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_own[i] = 0; m_last[i] = 2; m_cnt[i] = 0;
    m_wr[i] = 0; m_rd[i] = 0;
    m_addr[i] = '0; m_din[i] = '0; m_sel[i] = '0; m_err[i] = '0;
    for (int k = 0; k < 16; k++) m_rv[i][k] = 2'b00;
  endtask

  task automatic model_step(input int i);
    int  mb, rl, n;
    bit  ga, gb, acc_a, acc_b;
    bit [1:0] set;
    mb = (i == 0) ? MB0 : MB1;
    rl = (i == 0) ? RL0 : RL1;
    ga = (m_own[i] == 1);
    gb = (m_own[i] == 2);
    acc_a = ga && (a_wr || a_rd);
    acc_b = gb && (b_wr || b_rd);
    set[0] = (a_wr || a_rd) && (!ga || (a_wr && a_rd));
    set[1] = (b_wr || b_rd) && (!gb || (b_wr && b_rd));
    m_rv[i][cyc % 16] = 2'b00;
    if (acc_a) begin
      m_wr[i] = a_wr; m_rd[i] = a_rd && !a_wr;
      m_addr[i] = a_addr; m_din[i] = a_din; m_sel[i] = a_bus_sel;
      if (m_rd[i]) m_rv[i][(cyc + 1 + rl) % 16][0] = 1'b1;
    end else if (acc_b) begin
      m_wr[i] = b_wr; m_rd[i] = b_rd && !b_wr;
      m_addr[i] = b_addr; m_din[i] = b_din; m_sel[i] = b_bus_sel;
      if (m_rd[i]) m_rv[i][(cyc + 1 + rl) % 16][1] = 1'b1;
    end else begin
      m_wr[i] = 0; m_rd[i] = 0;
    end
    m_err[i] = (err_clr ? 2'b00 : m_err[i]) | set;
    // n = accesses accepted so far in the current ownership
    if (m_own[i] == 0)          n = 0;
    else if (acc_a || acc_b)    n = (m_cnt[i] + 1 > mb) ? mb : m_cnt[i] + 1;
    else                        n = m_cnt[i];
    m_cnt[i] = n;
    case (m_own[i])
      0: begin
        if (a_req && b_req) m_own[i] = (m_last[i] == 2) ? 1 : 2;
        else if (a_req)     m_own[i] = 1;
        else if (b_req)     m_own[i] = 2;
      end
      1: if (!a_req || (n == mb && b_req)) begin m_own[i] = 0; m_last[i] = 1; end
      default: if (!b_req || (n == mb && a_req)) begin m_own[i] = 0; m_last[i] = 2; end
    endcase
  endtask

  task automatic check_inst(input int i, input logic ag, bg, rw, rr,
                            input logic [31:0] ra, input logic [63:0] rdin,
                            input logic [7:0] rs, input logic av, bv,
                            input logic [63:0] ard, brd, input logic [1:0] er);
    string p;
    p = $sformatf("i%0d", i);
    chk({p, " a_gnt"},       64'(ag),   64'(m_own[i] == 1));
    chk({p, " b_gnt"},       64'(bg),   64'(m_own[i] == 2));
    chk({p, " ram_wr"},      64'(rw),   64'(m_wr[i]));
    chk({p, " ram_rd"},      64'(rr),   64'(m_rd[i]));
    chk({p, " ram_addr"},    64'(ra),   64'(m_addr[i]));
    chk({p, " ram_din"},     rdin,      m_din[i]);
    chk({p, " ram_bus_sel"}, 64'(rs),   64'(m_sel[i]));
    chk({p, " a_rvalid"},    64'(av),   64'(m_rv[i][cyc % 16][0]));
    chk({p, " b_rvalid"},    64'(bv),   64'(m_rv[i][cyc % 16][1]));
    chk({p, " a_rdata"},     ard,       ram_dout);
    chk({p, " b_rdata"},     brd,       ram_dout);
    chk({p, " err_illegal"}, 64'(er),   64'(m_err[i]));
  endtask

  task automatic check_all();
    check_inst(0, bus0.a_gnt, bus0.b_gnt, bus0.ram_wr, bus0.ram_rd, bus0.ram_addr,
               bus0.ram_din, bus0.ram_bus_sel, bus0.a_rvalid, bus0.b_rvalid,
               bus0.a_rdata, bus0.b_rdata, bus0.err_illegal);
    check_inst(1, bus1.a_gnt, bus1.b_gnt, bus1.ram_wr, bus1.ram_rd, bus1.ram_addr,
               bus1.ram_din, bus1.ram_bus_sel, bus1.a_rvalid, bus1.b_rvalid,
               bus1.a_rdata, bus1.b_rdata, bus1.err_illegal);
  endtask

  // Inputs are set just after a rising edge; check and advance the model mid-cycle.
  task automatic run_cycle();
    @(negedge sys_clk);
    check_all();
    model_step(0);
    model_step(1);
    cyc++;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_strobes();
    a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0; err_clr = 0;
  endtask

  task automatic rand_stim();
    int r;
    if ($urandom_range(0, 7) == 0) a_req = ~a_req;
    if ($urandom_range(0, 7) == 0) b_req = ~b_req;
    clear_strobes();
    if (m_own[0] == 1 || $urandom_range(0, 99) < 3) begin
      r = $urandom_range(0, 99);
      a_wr = (r < 40) || (r >= 95);
      a_rd = (r >= 40 && r < 80) || (r >= 95);
    end
    if (m_own[0] == 2 || $urandom_range(0, 99) < 3) begin
      r = $urandom_range(0, 99);
      b_wr = (r < 40) || (r >= 95);
      b_rd = (r >= 40 && r < 80) || (r >= 95);
    end
    err_clr   = ($urandom_range(0, 15) == 0);
    a_addr    = $urandom;
    b_addr    = $urandom;
    a_din     = {$urandom, $urandom};
    b_din     = {$urandom, $urandom};
    a_bus_sel = 8'($urandom_range(0, 255));
    b_bus_sel = 8'($urandom_range(0, 255));
    ram_dout  = {$urandom, $urandom};
  endtask

  initial begin
    sys_rst_n = 1'b0;
    a_req = 0; b_req = 0; clear_strobes();
    a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
    a_bus_sel = '0; b_bus_sel = '0; ram_dout = 64'h1122334455667788;
    model_reset(0);
    model_reset(1);
    #2;
    check_all();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Directed prelude: tie from reset, A read, A release + stray B write,
    // then a B read so returns cross the handover.
    a_req = 1; b_req = 1;
    for (int k = 0; k < 12; k++) begin
      clear_strobes();
      ram_dout = {$urandom, $urandom};
      if (k == 1) begin a_rd = 1; a_addr = 32'h40; end
      if (k == 2) begin a_req = 0; b_wr = 1; end
      if (k == 3) begin a_wr = 1; a_rd = 1; end
      if (k == 4) begin b_rd = 1; b_addr = 32'h80; end
      if (k == 6) err_clr = 1;
      if (k == 8) begin a_req = 1; b_req = 0; end
      run_cycle();
    end

    for (int k = 0; k < 3000; k++) begin
      if (k % 300 == 299) begin
        // asynchronous reset mid-operation, checked before any clock edge
        sys_rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all();
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
      end
      rand_stim();
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
